serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-to-serial frame transmitter that drives a single-bit line one bit at a time. It accepts a WIDTH-bit word over a valid/ready handshake and emits a start bit, the data LSB first, and a stop bit. Each bit is held for CLKS_PER_BIT clocks. It is the sending end of the single-bit sampled data path that our capture flops and receivers consume.

Parameters:
WIDTH, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clocks each serial bit is held (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  in_data is presented for transmission
in_data  input  WIDTH  word to send; sampled only at acceptance
in_ready  output  1  block can accept a word (state==IDLE)
tx  output  1  serial line; idles high
busy  output  1  frame in progress (state!=IDLE)
done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- One clock, clk. Reset is asynchronous and active-high: rst=1 forces all flops immediately, with no clock edge needed.
- Reset values: state=IDLE, tx=1, busy=0, done=0, bit counter=0, clock counter=0, shift register=0.
- in_ready is a combinational decode of state==IDLE, so it reads 1 while rst is high. No word is accepted while rst=1.
- tx, busy and done are registered outputs.
- States: IDLE -> START -> DATA -> STOP -> IDLE. PARITY sits between DATA and STOP only when PARITY_EN is defined.
- IDLE:
  - tx=1.
  - Acceptance is in_valid && in_ready at a rising edge E0.
  - At E0: in_data is loaded into the shift register and state goes to START.
  - tx=0 from E0 onward.
- Bit timing: a clock counter runs 0..CLKS_PER_BIT-1. The state or bit advances on the edge where the counter equals CLKS_PER_BIT-1, and the counter wraps to 0.
  - CLKS_PER_BIT=1 means a bit change every clock.
- DATA:
  - tx = shift register bit 0; the register shifts right at each bit boundary.
  - A bit counter runs 0..WIDTH-1; the state leaves DATA after bit WIDTH-1.
- STOP: tx=1 for CLKS_PER_BIT clocks.
- End of frame: at edge E0+(WIDTH+2)*CLKS_PER_BIT:
  - state -> IDLE, busy -> 0, done -> 1 for exactly one cycle.
  - in_ready is 1 in that same cycle.
- Frame spacing: minimum spacing between acceptances is (WIDTH+2)*CLKS_PER_BIT+1 clocks, i.e. one IDLE cycle (tx=1) between back-to-back frames.
- Input hold rules:
  - in_valid held high while busy is not accepted; the word waits and the handshake completes on the first IDLE edge.
  - in_data changes after acceptance have no effect on the frame in flight.
- Reset mid-frame:
  - tx=1 and busy=0 asynchronously; the frame is aborted and no done pulse is produced.
  - After rst deasserts, the next accepted word transmits a complete, clean frame.
- No back-pressure on tx; the line is always driven.

Optional Feature:
Macro PARITY_EN.
- Defined:
  - PARITY state inserted after DATA, lasting CLKS_PER_BIT clocks.
  - tx = even parity = XOR of all WIDTH data bits, computed from the word latched at acceptance.
  - Frame is WIDTH+3 bits; done arrives at E0+(WIDTH+3)*CLKS_PER_BIT.
- Undefined:
  - No PARITY state, no parity logic; frame is WIDTH+2 bits.

Test Plan:
1. Reset: rst=1 with no clock edges -> tx=1, busy=0, done=0, in_ready=1. Assert rst mid-cycle and confirm outputs change without waiting for clk.
2. WIDTH=8, CLKS_PER_BIT=4, send 0xA5 -> tx holds each bit 4 clocks: 0 | 1,0,1,0,0,1,0,1 | 1. busy=1 for 40 clocks; done=1 for one cycle exactly 40 edges after acceptance.
3. Send 0x3C, then change in_data to 0xFF and hold in_valid=1 during the frame -> serial data bits are 0,0,1,1,1,1,0,0. 0xFF is accepted on the first cycle in_ready=1 after done.
4. Assert rst asynchronously during data bit 3 of 0xA5 -> tx=1 and busy=0 immediately, no done pulse. After release, send 0x81 -> complete frame 0 | 1,0,0,0,0,0,0,1 | 1.
5. CLKS_PER_BIT=1, in_valid held high with 0x00 then 0xFF -> 10-clock frames with exactly one tx=1 idle clock between them; done pulses 11 clocks apart.
6. PARITY_EN defined, CLKS_PER_BIT=4:
   - 0x07 -> parity bit 1, done at 44 clocks.
   - 0x03 -> parity bit 0.
   - Without the macro, both frames end at 40 clocks.

Source files
------------

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
//
// Accepts a WIDTH-bit word over a valid/ready handshake. It then drives a
// single-bit line with a start bit (0), the data LSB first, and a stop bit (1).
// Each bit is held for CLKS_PER_BIT clocks. The line idles high.
//
// Optional feature: define PARITY_EN to insert an even-parity bit between the
// last data bit and the stop bit. The parity is the XOR of the word latched at
// acceptance.
//
// Parameters:
//   WIDTH        data bits per frame (>=1)
//   CLKS_PER_BIT clocks each serial bit is held (>=1)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   in_valid  word on in_data is offered for transmission
//   in_data   word to send, sampled only at acceptance
//   in_ready  combinational, high while idle
//   tx        registered serial line, idles high
//   busy      registered, high while a frame is in progress
//   done      registered, one-cycle pulse as the stop bit completes
module serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t           r_state;
  logic [CW-1:0]    r_clkCnt;
  logic [BW-1:0]    r_bitCnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_tx;
  logic             r_busy;
  logic             r_done;

  state_t           w_stateNext;
  logic [CW-1:0]    w_clkCntNext;
  logic [BW-1:0]    w_bitCntNext;
  logic [WIDTH-1:0] w_shiftNext;
  logic [WIDTH-1:0] w_shifted;
  logic             w_txNext;
  logic             w_busyNext;
  logic             w_doneNext;
  logic             w_bitEnd;

`ifdef PARITY_EN
  logic r_parity;
  logic w_parityNext;
`endif

  // A bit period ends on the clock where the counter has reached its last value.
  assign w_bitEnd  = (r_clkCnt == CLK_LAST);
  assign w_shifted = r_shift >> 1;
  assign in_ready  = (r_state == S_IDLE);
  assign tx        = r_tx;
  assign busy      = r_busy;
  assign done      = r_done;

  // State register and all datapath registers.
  // tx comes up high and busy low as soon as rst asserts, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_clkCnt <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_stateNext;
      r_clkCnt <= w_clkCntNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
`ifdef PARITY_EN
      r_parity <= w_parityNext;
`endif
    end
  end

  // Next-state and next-output decode.
  // tx is computed one clock early: the value loaded at a bit boundary is the
  // bit that belongs to the state being entered.
  always_comb begin
    w_stateNext  = r_state;
    w_clkCntNext = w_bitEnd ? '0 : r_clkCnt + 1'b1;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_txNext     = r_tx;
    w_busyNext   = r_busy;
    w_doneNext   = 1'b0;
`ifdef PARITY_EN
    w_parityNext = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_txNext     = 1'b1;
        w_busyNext   = 1'b0;
        w_clkCntNext = '0;
        w_bitCntNext = '0;
        if (in_valid) begin
          w_stateNext = S_START;
          w_shiftNext = in_data;
          w_txNext    = 1'b0;
          w_busyNext  = 1'b1;
`ifdef PARITY_EN
          w_parityNext = ^in_data;
`endif
        end
      end

      S_START: begin
        if (w_bitEnd) begin
          w_stateNext = S_DATA;
          w_txNext    = r_shift[0];
        end
      end

      S_DATA: begin
        if (w_bitEnd) begin
          if (r_bitCnt == BIT_LAST) begin
`ifdef PARITY_EN
            w_stateNext = S_PARITY;
            w_txNext    = r_parity;
`else
            w_stateNext = S_STOP;
            w_txNext    = 1'b1;
`endif
          end else begin
            w_shiftNext  = w_shifted;
            w_txNext     = w_shifted[0];
            w_bitCntNext = r_bitCnt + 1'b1;
          end
        end
      end

`ifdef PARITY_EN
      S_PARITY: begin
        if (w_bitEnd) begin
          w_stateNext = S_STOP;
          w_txNext    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (w_bitEnd) begin
          w_stateNext = S_IDLE;
          w_txNext    = 1'b1;
          w_busyNext  = 1'b0;
          w_doneNext  = 1'b1;
        end
      end

      default: begin
        w_stateNext = S_IDLE;
        w_txNext    = 1'b1;
        w_busyNext  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx.
// Instance A uses WIDTH=8 and CLKS_PER_BIT=4. Instance B uses WIDTH=8 and
// CLKS_PER_BIT=1. A frame-level model predicts tx/busy/done/in_ready for both
// instances. Directed scenarios add hand-computed frame contents and timing.
// Define PARITY_EN to build with the parity bit enabled.
module tb_serial_tx;

`ifdef PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inValidA = 1'b0;
  logic [7:0] inDataA  = 8'h00;
  logic       inValidB = 1'b0;
  logic [7:0] inDataB  = 8'h00;
  logic       readyA, txA, busyA, doneA;
  logic       readyB, txB, busyB, doneB;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  bit stimDone = 1'b0;

  // Model state: active frame flag, edges since acceptance, frame bit
  // pattern, and the expected done pulse.
  bit          mAct[2];
  int          mK[2];
  logic [15:0] mFrame[2];
  bit          mDone[2];

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dutA (
    .clk(clk), .rst(rst), .in_valid(inValidA), .in_data(inDataA),
    .in_ready(readyA), .tx(txA), .busy(busyA), .done(doneA));

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dutB (
    .clk(clk), .rst(rst), .in_valid(inValidB), .in_data(inDataB),
    .in_ready(readyB), .tx(txB), .busy(busyB), .done(doneB));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cpbOf(input int u);
    return (u == 0) ? 4 : 1;
  endfunction

  // Frame bit i is what the line carries during the i-th bit period.
  // Bits past the stop bit read as 1 (idle).
  function automatic logic [15:0] frameOf(input logic [7:0] d);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = d[i];
      if (d[i]) ones++;
    end
`ifdef PARITY_EN
    f[9] = (ones % 2 == 1);
`endif
    return f;
  endfunction

  // Hand-assembled literal frame: start, data, parity p (if enabled), stop.
  function automatic logic [15:0] litFrame(input logic [7:0] d, input logic p);
`ifdef PARITY_EN
    return {5'b11111, 1'b1, p, d, 1'b0};
`else
    return {6'b111111, 1'b1, d, 1'b0};
`endif
  endfunction

  // Model update: a frame lasts NBITS*cpb edges after acceptance.
  // Acceptance happens only from idle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        mAct[u]  <= 1'b0;
        mK[u]    <= 0;
        mDone[u] <= 1'b0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        mDone[u] <= 1'b0;
        if (mAct[u]) begin
          if (mK[u] + 1 == NBITS * cpbOf(u)) begin
            mAct[u]  <= 1'b0;
            mK[u]    <= 0;
            mDone[u] <= 1'b1;
          end else begin
            mK[u] <= mK[u] + 1;
          end
        end else if ((u == 0) ? inValidA : inValidB) begin
          mAct[u]   <= 1'b1;
          mK[u]     <= 0;
          mFrame[u] <= frameOf((u == 0) ? inDataA : inDataB);
        end
      end
    end
  end

  function automatic logic expTx(input int u);
    if (!mAct[u]) return 1'b1;
    return mFrame[u][mK[u] / cpbOf(u)];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic compareAll();
    checkOutput("A.tx",    32'(txA),    32'(expTx(0)));
    checkOutput("A.busy",  32'(busyA),  32'(mAct[0]));
    checkOutput("A.done",  32'(doneA),  32'(mDone[0]));
    checkOutput("A.ready", 32'(readyA), 32'(!mAct[0]));
    checkOutput("B.tx",    32'(txB),    32'(expTx(1)));
    checkOutput("B.busy",  32'(busyB),  32'(mAct[1]));
    checkOutput("B.done",  32'(doneB),  32'(mDone[1]));
    checkOutput("B.ready", 32'(readyB), 32'(!mAct[1]));
  endtask

  // Offer a word to A and wait for acceptance. Returns 1ns after the
  // accepting edge. in_valid stays high when hold is set.
  task automatic applyStimulus(input logic [7:0] d, input bit hold);
    bit seen;
    seen = 1'b0;
    inValidA = 1'b1;
    inDataA  = d;
    for (int i = 0; i < 200; i++) begin
      if (readyA) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) checkOutput("A.acceptTimeout", 32'(readyA), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) inValidA = 1'b0;
  endtask

  // Sample each A bit mid-period, then check done one edge past the frame.
  task automatic captureA(input string name, output logic [15:0] seen);
    seen = '1;
    for (int k = 0; k < NBITS * 4; k++) begin
      @(negedge clk);
      if (k % 4 == 2) seen[k / 4] = txA;
    end
    @(negedge clk);
    checkOutput({name, ".doneLatency"}, 32'(doneA), 32'd1);
  endtask

  task automatic waitDoneB(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (doneB) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic idleGap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] seen;
    int acc, d1, d2;
    fork
      begin
        while (!stimDone) begin
          @(negedge clk);
          compareAll();
        end
      end
      begin
        // Reset with no clock edge yet.
        rst = 1'b1;
        #2;
        checkOutput("rst.tx",    32'(txA),    32'd1);
        checkOutput("rst.busy",  32'(busyA),  32'd0);
        checkOutput("rst.done",  32'(doneA),  32'd0);
        checkOutput("rst.ready", 32'(readyA), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idleGap();

        // 0xA5, bits held 4 clocks each.
        applyStimulus(8'hA5, 1'b0);
        captureA("A5", seen);
        checkOutput("A5.frame", 32'(seen), 32'(litFrame(8'hA5, 1'b0)));
        idleGap();

        // 0x3C with valid held and data changed mid-frame; 0xFF follows.
        applyStimulus(8'h3C, 1'b1);
        inDataA = 8'hFF;
        captureA("3C", seen);
        checkOutput("3C.frame", 32'(seen), 32'(litFrame(8'h3C, 1'b0)));
        checkOutput("3C.readyAfterDone", 32'(readyA), 32'd1);
        applyStimulus(8'hFF, 1'b0);
        captureA("FF", seen);
        checkOutput("FF.frame", 32'(seen), 32'(litFrame(8'hFF, 1'b0)));
        idleGap();

        // Async reset during data bit 3 of 0xA5.
        applyStimulus(8'hA5, 1'b0);
        repeat (18) @(negedge clk);
        checkOutput("abort.txBefore", 32'(txA), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort.tx",    32'(txA),    32'd1);
        checkOutput("abort.busy",  32'(busyA),  32'd0);
        checkOutput("abort.done",  32'(doneA),  32'd0);
        checkOutput("abort.ready", 32'(readyA), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        idleGap();
        applyStimulus(8'h81, 1'b0);
        captureA("81", seen);
        checkOutput("81.frame", 32'(seen), 32'(litFrame(8'h81, 1'b0)));
        idleGap();

        // CLKS_PER_BIT=1, back-to-back frames with valid held.
        inValidB = 1'b1;
        inDataB  = 8'h00;
        @(posedge clk);
        #1;
        acc = cyc;
        inDataB = 8'hFF;
        waitDoneB(d1);
        waitDoneB(d2);
        inValidB = 1'b0;
        checkOutput("B.firstDone", 32'(d1 - acc), 32'(NBITS));
        checkOutput("B.doneSpacing", 32'(d2 - d1), 32'(NBITS + 1));
        idleGap();

        // Parity frames: 0x07 has odd weight, 0x03 even.
        applyStimulus(8'h07, 1'b0);
        captureA("07", seen);
        checkOutput("07.frame", 32'(seen), 32'(litFrame(8'h07, 1'b1)));
        idleGap();
        applyStimulus(8'h03, 1'b0);
        captureA("03", seen);
        checkOutput("03.frame", 32'(seen), 32'(litFrame(8'h03, 1'b0)));
        idleGap();

        stimDone = 1'b1;
      end
    join
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
